// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register in-flight write counters between issue and
// writeback, producing the issue stall and busy/pending status for the hazard logic.
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        issue_valid_i,
  input  logic        issue_we_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  issue_rs_i,
  input  logic [4:0]  issue_rt_i,
  input  logic        issue_use_rt_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  output logic        stall_o,
  output logic        issue_ack_o,
  output logic [31:0] busy_o,
  output logic [5:0]  pending_o,
  output logic        err_o
);

  localparam int unsigned NREG   = 32;
  localparam int unsigned PEND_W = 6;
  localparam int unsigned SUM_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SUM_W-1:0] PEND_SAT = SUM_W'(63);

  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;

  logic rs_pend, rt_pend, rd_full, raw, wb_nz, wb_hits_rd;
  logic [SUM_W-1:0] sum;

  // A writeback retiring the last in-flight write releases the register in the same cycle.
  always_comb begin
    wb_nz      = wb_valid_i && (wb_rd_i != 5'd0);
    wb_hits_rd = wb_valid_i && (wb_rd_i == issue_rd_i);
    rs_pend = (issue_rs_i != 5'd0) && (cnt_q[issue_rs_i] != '0) &&
              !(wb_valid_i && (wb_rd_i == issue_rs_i) && (cnt_q[issue_rs_i] == CNT_W'(1)));
    rt_pend = (issue_rt_i != 5'd0) && (cnt_q[issue_rt_i] != '0) &&
              !(wb_valid_i && (wb_rd_i == issue_rt_i) && (cnt_q[issue_rt_i] == CNT_W'(1)));
    rd_full = issue_we_i && (issue_rd_i != 5'd0) && (cnt_q[issue_rd_i] == CNT_MAX) &&
              !wb_hits_rd;
    raw         = rs_pend || (issue_use_rt_i && rt_pend);
    stall_o     = issue_valid_i && (raw || rd_full);
    issue_ack_o = issue_valid_i && !stall_o;
  end

  // Next-state counters, sticky error and registered status.
  always_comb begin
    err_d = err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    cnt_d[0] = '0;
    if (flush_i) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
    end else begin
      if (wb_nz && (cnt_q[wb_rd_i] == '0)) begin
        err_d = 1'b1;
      end
      for (int unsigned r = 1; r < NREG; r++) begin
        cnt_d[r] = cnt_q[r]
                 + CNT_W'(issue_ack_o && issue_we_i && (issue_rd_i == 5'(r)))
                 - CNT_W'(wb_valid_i && (wb_rd_i == 5'(r)) && (cnt_q[r] != '0));
      end
    end

    sum    = '0;
    busy_d = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      sum       = sum + SUM_W'(cnt_d[r]);
      busy_d[r] = (cnt_d[r] != '0);
    end
    pend_d = (sum > PEND_SAT) ? PEND_W'(63) : sum[PEND_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign busy_o    = busy_q;
  assign pending_o = pend_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: reference model predicts stall/ack per cycle and
// queues expected registered status, compared after the following clock edge.
module tb_reg_scoreboard;

  typedef struct packed {
    logic [31:0] busy;
    logic [5:0]  pend;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_i, flush_i, issue_valid_i, issue_we_i, issue_use_rt_i, wb_valid_i;
  logic [4:0]  issue_rd_i, issue_rs_i, issue_rt_i, wb_rd_i;
  logic        stall_o, issue_ack_o, err_o;
  logic [31:0] busy_o;
  logic [5:0]  pending_o;

  int   n_vec = 0;
  int   n_err = 0;
  int   mcnt[32];
  logic merr;
  logic last_stall, last_ack;
  exp_t exp_q[$];

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i),
    .issue_rd_i(issue_rd_i), .issue_rs_i(issue_rs_i), .issue_rt_i(issue_rt_i),
    .issue_use_rt_i(issue_use_rt_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .stall_o(stall_o), .issue_ack_o(issue_ack_o), .busy_o(busy_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic eff_pend(input logic [4:0] r, input logic wbv, input logic [4:0] wbrd);
    return (r != 5'd0) && (mcnt[r] != 0) && !(wbv && (wbrd == r) && (mcnt[r] == 1));
  endfunction

  // One clock of stimulus: check combinational outputs, queue expected state, check it after the edge.
  task automatic cyc(input logic r, input logic f, input logic v, input logic we,
                     input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic wbv, input logic [4:0] wbrd);
    exp_t e, got_e;
    int   nc[32];
    int   sum;
    logic st, ack, full, nerr;
    rst_i = r; flush_i = f; issue_valid_i = v; issue_we_i = we;
    issue_rd_i = rd; issue_rs_i = rs; issue_rt_i = rt; issue_use_rt_i = urt;
    wb_valid_i = wbv; wb_rd_i = wbrd;
    #2;
    full = we && (rd != 5'd0) && (mcnt[rd] == 3) && !(wbv && (wbrd == rd));
    st   = v && (eff_pend(rs, wbv, wbrd) || (urt && eff_pend(rt, wbv, wbrd)) || full);
    ack  = v && !st;
    last_stall = stall_o;
    last_ack   = issue_ack_o;
    chk("stall", 32'(stall_o), 32'(st));
    chk("ack", 32'(issue_ack_o), 32'(ack));

    for (int i = 0; i < 32; i++) nc[i] = mcnt[i];
    nerr = merr;
    if (r) begin
      for (int i = 0; i < 32; i++) nc[i] = 0;
      nerr = 1'b0;
    end else if (f) begin
      for (int i = 0; i < 32; i++) nc[i] = 0;
    end else begin
      if (ack && we && (rd != 5'd0)) nc[rd]++;
      if (wbv && (wbrd != 5'd0)) begin
        if (mcnt[wbrd] != 0) nc[wbrd]--;
        else nerr = 1'b1;
      end
    end
    sum = 0;
    e.busy = '0;
    for (int i = 1; i < 32; i++) begin
      sum += nc[i];
      e.busy[i] = (nc[i] != 0);
    end
    e.pend = (sum > 63) ? 6'd63 : 6'(sum);
    e.err  = nerr;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    chk("busy", busy_o, got_e.busy);
    chk("pending", 32'(pending_o), 32'(got_e.pend));
    chk("err", 32'(err_o), 32'(got_e.err));
    for (int i = 0; i < 32; i++) mcnt[i] = nc[i];
    merr = nerr;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0);
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt);
    cyc(0, 0, 1, we, rd, rs, rt, urt, 0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr = 1'b0;
    rst_i = 1'b1; flush_i = 0; issue_valid_i = 0; issue_we_i = 0; issue_use_rt_i = 0;
    wb_valid_i = 0; issue_rd_i = 0; issue_rs_i = 0; issue_rt_i = 0; wb_rd_i = 0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state with an issue request present: nothing pending, ack follows valid.
    cyc(1, 0, 1, 0, 5'd0, 5'd1, 5'd2, 1, 0, 5'd0);
    chk("rst_ack", 32'(last_ack), 32'd1);
    chk("rst_busy", busy_o, 32'd0);

    // Basic RAW on rd=8 and same-cycle writeback release.
    issue(1, 5'd8, 5'd0, 5'd0, 0);
    chk("plan_busy8", 32'(busy_o[8]), 32'd1);
    chk("plan_pend1", 32'(pending_o), 32'd1);
    issue(0, 5'd0, 5'd8, 5'd0, 0);
    chk("plan_raw_stall", 32'(last_stall), 32'd1);
    cyc(0, 0, 1, 0, 5'd0, 5'd8, 5'd0, 0, 1, 5'd8);
    chk("plan_wb_release", 32'(last_stall), 32'd0);
    chk("plan_busy8_clr", 32'(busy_o[8]), 32'd0);

    // Register 0 is never tracked.
    issue(1, 5'd0, 5'd0, 5'd0, 0);
    issue(0, 5'd0, 5'd0, 5'd0, 1);
    chk("r0_stall", 32'(last_stall), 32'd0);
    chk("r0_busy", busy_o, 32'd0);
    chk("r0_pend", 32'(pending_o), 32'd0);

    // FULL on rd=5, then accepted when writeback to 5 coincides.
    repeat (3) issue(1, 5'd5, 5'd0, 5'd0, 0);
    chk("full_pend3", 32'(pending_o), 32'd3);
    issue(1, 5'd5, 5'd0, 5'd0, 0);
    chk("full_stall", 32'(last_stall), 32'd1);
    cyc(0, 0, 1, 1, 5'd5, 5'd0, 5'd0, 0, 1, 5'd5);
    chk("full_wb_ack", 32'(last_ack), 32'd1);
    chk("full_keep3", 32'(pending_o), 32'd3);
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0);

    // rt only matters when used.
    issue(1, 5'd9, 5'd0, 5'd0, 0);
    issue(1, 5'd9, 5'd0, 5'd9, 0);
    chk("rt_unused", 32'(last_stall), 32'd0);
    issue(1, 5'd9, 5'd0, 5'd9, 1);
    chk("rt_used", 32'(last_stall), 32'd1);

    // Sticky error: survives flush, cleared by reset.
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0);
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd12);
    chk("err_set", 32'(err_o), 32'd1);
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0);
    chk("err_flush", 32'(err_o), 32'd1);
    cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0);
    chk("err_rst", 32'(err_o), 32'd0);

    // Flush clears pending; a stalled dependent is then accepted.
    issue(1, 5'd3, 5'd0, 5'd0, 0);
    issue(1, 5'd4, 5'd0, 5'd0, 0);
    issue(1, 5'd7, 5'd0, 5'd0, 0);
    cyc(0, 1, 1, 0, 5'd0, 5'd3, 5'd0, 0, 0, 5'd0);
    chk("flush_mid_stall", 32'(last_stall), 32'd1);
    chk("flush_busy", busy_o, 32'd0);
    chk("flush_pend", 32'(pending_o), 32'd0);
    issue(0, 5'd0, 5'd3, 5'd0, 0);
    chk("flush_release", 32'(last_ack), 32'd1);

    // Flush wins over a simultaneous issue.
    cyc(0, 1, 1, 1, 5'd6, 5'd0, 5'd0, 0, 0, 5'd0);
    chk("flush_issue_busy", busy_o, 32'd0);

    // Fill every register to max: pending saturates at 63.
    for (int r = 1; r < 32; r++) begin
      repeat (3) issue(1, 5'(r), 5'd0, 5'd0, 0);
    end
    chk("sat_pend", 32'(pending_o), 32'd63);
    chk("sat_busy", busy_o, 32'hFFFF_FFFE);

    // Random mix against the model.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
